// File: rtl/stim_scheduler.sv
// Table-driven register scheduler: up to four {target, value, delay} events applied in order per run.
// Optional edge monitors on a[0]/b[1] are built only when STIM_EDGE_MON_EN is defined.
module stim_scheduler #(
  parameter int NUM_EVT = 4,
  parameter int MON_DLY = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_idx,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_val,
  input  logic [7:0] cfg_dly,
  input  logic [2:0] cfg_len,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       mon_a,
  output logic       mon_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is a level sampled only in IDLE (with abort low); done is a
  // one-cycle pulse; busy is high exactly while the FSM is in RUN.
  state_t     state;
  logic [1:0] tbl_sel [NUM_EVT];
  logic [7:0] tbl_val [NUM_EVT];
  logic [7:0] tbl_dly [NUM_EVT];
  logic [2:0] len;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       last_evt;
  logic       due;

  if (NUM_EVT != 4 || MON_DLY < 2) begin : g_param_check
    $error("stim_scheduler: NUM_EVT must be 4 and MON_DLY at least 2");
  end

  assign last_evt = ({1'b0, idx} == (len - 3'd1));
  assign due      = (cnt == tbl_dly[idx]);

  // cnt restarts at 0 on each reference edge, so an event lands dly+1 edges later
  // and an 8-bit counter reaches 255 without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      len   <= 3'd0;
      idx   <= 2'd0;
      cnt   <= 8'd0;
      a     <= 8'd0;
      b     <= 8'd0;
      c     <= 8'd0;
      d     <= 8'd0;
      for (int i = 0; i < NUM_EVT; i++) begin
        tbl_sel[i] <= 2'd0;
        tbl_val[i] <= 8'd0;
        tbl_dly[i] <= 8'd0;
      end
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (cfg_we) begin
            tbl_sel[cfg_idx] <= cfg_sel;
            tbl_val[cfg_idx] <= cfg_val;
            tbl_dly[cfg_idx] <= cfg_dly;
          end
          if (start && !abort) begin
            len <= (cfg_len > 3'd4) ? 3'd4 : cfg_len;
            idx <= 2'd0;
            cnt <= 8'd0;
            if (cfg_len == 3'd0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (due) begin
            case (tbl_sel[idx])
              2'd0: a <= tbl_val[idx];
              2'd1: b <= tbl_val[idx];
              2'd2: c <= tbl_val[idx];
              default: d <= tbl_val[idx];
            endcase
            cnt <= 8'd0;
            if (last_evt) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STIM_EDGE_MON_EN
  // The rise is seen one edge late (through the delayed copy), so the countdown
  // loads MON_DLY-2 to land the pulse MON_DLY edges after the source edge.
  localparam logic [7:0] MON_LOAD = 8'(MON_DLY - 2);

  logic       a0_q;
  logic       b1_q;
  logic       pend_a;
  logic       pend_b;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q   <= 1'b0;
      b1_q   <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      cnt_a  <= 8'd0;
      cnt_b  <= 8'd0;
      mon_a  <= 1'b0;
      mon_b  <= 1'b0;
    end else begin
      a0_q  <= a[0];
      b1_q  <= b[1];
      mon_a <= 1'b0;
      mon_b <= 1'b0;
      if (pend_a) begin
        if (cnt_a == 8'd0) begin
          mon_a  <= 1'b1;
          pend_a <= 1'b0;
        end else begin
          cnt_a <= cnt_a - 8'd1;
        end
      end else if (a[0] && !a0_q) begin
        pend_a <= 1'b1;
        cnt_a  <= MON_LOAD;
      end
      if (pend_b) begin
        if (cnt_b == 8'd0) begin
          mon_b  <= 1'b1;
          pend_b <= 1'b0;
        end else begin
          cnt_b <= cnt_b - 8'd1;
        end
      end else if (b[1] && !b1_q) begin
        pend_b <= 1'b1;
        cnt_b  <= MON_LOAD;
      end
    end
  end
`else
  assign mon_a = 1'b0;
  assign mon_b = 1'b0;
`endif

endmodule

// File: tb/tb_stim_scheduler.sv
// Directed bench for stim_scheduler: vector tables for the reference run and single-event
// runs, plus hand-written sequences for len=0, abort, ignored config/start, and mid-run reset.
module tb_stim_scheduler;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_val;
  logic [7:0] cfg_dly;
  logic [2:0] cfg_len;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] a, b, c, d;
  logic       mon_a, mon_b;

  int total = 0;
  int bad   = 0;

`ifdef STIM_EDGE_MON_EN
  localparam bit MON_ON = 1'b1;
`else
  localparam bit MON_ON = 1'b0;
`endif

  stim_scheduler #(.NUM_EVT(4), .MON_DLY(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_val(cfg_val), .cfg_dly(cfg_dly), .cfg_len(cfg_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .a(a), .b(b), .c(c), .d(d), .mon_a(mon_a), .mon_b(mon_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] a, b, c, d;
    logic       busy, done;
  } tvec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] val;
    logic [7:0] dly;
    int         wk;
  } svec_t;

  tvec_t      tv[9];
  svec_t      sv[4];
  logic [7:0] exp_reg[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] i, input logic [1:0] s, input logic [7:0] v, input logic [7:0] dl);
    cfg_we = 1'b1; cfg_idx = i; cfg_sel = s; cfg_val = v; cfg_dly = dl;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] l);
    cfg_len = l;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  function automatic logic [7:0] get_reg(input logic [1:0] s);
    case (s)
      2'd0: return a;
      2'd1: return b;
      2'd2: return c;
      default: return d;
    endcase
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, ".a"}, a, exp_reg[0]);
    chk({tag, ".b"}, b, exp_reg[1]);
    chk({tag, ".c"}, c, exp_reg[2]);
    chk({tag, ".d"}, d, exp_reg[3]);
  endtask

  initial begin
    bit seen_done;

    // reference run: sampled after edge T0+k
    tv[0] = '{0,  8'd0, 8'd0,  8'd0,  8'd0,  1'b1, 1'b0};
    tv[1] = '{4,  8'd0, 8'd0,  8'd0,  8'd0,  1'b1, 1'b0};
    tv[2] = '{5,  8'd5, 8'd0,  8'd0,  8'd0,  1'b1, 1'b0};
    tv[3] = '{6,  8'd5, 8'd10, 8'd0,  8'd0,  1'b1, 1'b0};
    tv[4] = '{10, 8'd5, 8'd10, 8'd0,  8'd0,  1'b1, 1'b0};
    tv[5] = '{11, 8'd5, 8'd10, 8'd15, 8'd0,  1'b1, 1'b0};
    tv[6] = '{12, 8'd5, 8'd10, 8'd15, 8'd20, 1'b0, 1'b0};
    tv[7] = '{13, 8'd5, 8'd10, 8'd15, 8'd20, 1'b0, 1'b1};
    tv[8] = '{14, 8'd5, 8'd10, 8'd15, 8'd20, 1'b0, 1'b0};

    // single-event runs: wk is the cycle the write becomes visible
    sv[0] = '{2'd0, 8'h11, 8'd0,   1};
    sv[1] = '{2'd3, 8'h22, 8'd2,   3};
    sv[2] = '{2'd2, 8'h33, 8'd255, 256};
    sv[3] = '{2'd1, 8'hA5, 8'd7,   8};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_sel = 2'd0; cfg_val = 8'd0;
    cfg_dly = 8'd0; cfg_len = 3'd0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.abcd", {a, b, c, d}, 0);
    chk("rst.mon", {mon_a, mon_b}, 0);
    rst_n = 1'b1;
    step();

    // reference run, cfg_len=7 clamps to 4
    wr(0, 2'd0, 8'd5, 8'd4);
    wr(1, 2'd1, 8'd10, 8'd0);
    wr(2, 2'd2, 8'd15, 8'd4);
    wr(3, 2'd3, 8'd20, 8'd0);
    start_run(3'd7);
    begin
      int j = 0;
      for (int k = 0; k <= 14; k++) begin
        if (j < 9 && tv[j].k == k) begin
          chk($sformatf("ref.k%0d.a", k), a, tv[j].a);
          chk($sformatf("ref.k%0d.b", k), b, tv[j].b);
          chk($sformatf("ref.k%0d.c", k), c, tv[j].c);
          chk($sformatf("ref.k%0d.d", k), d, tv[j].d);
          chk($sformatf("ref.k%0d.busy", k), busy, tv[j].busy);
          chk($sformatf("ref.k%0d.done", k), done, tv[j].done);
          j++;
        end
        chk($sformatf("ref.k%0d.mon_a", k), mon_a, (MON_ON && k == 10) ? 1 : 0);
        chk($sformatf("ref.k%0d.mon_b", k), mon_b, (MON_ON && k == 11) ? 1 : 0);
        if (k < 14) step();
      end
    end
    exp_reg[0] = 8'd5; exp_reg[1] = 8'd10; exp_reg[2] = 8'd15; exp_reg[3] = 8'd20;

    // single-event vectors, including the 256-cycle spacing
    for (int i = 0; i < 4; i++) begin
      wr(0, sv[i].sel, sv[i].val, sv[i].dly);
      start_run(3'd1);
      for (int k = 0; k < sv[i].wk - 1; k++) step();
      chk($sformatf("sv%0d.before", i), get_reg(sv[i].sel), exp_reg[sv[i].sel]);
      step();
      exp_reg[sv[i].sel] = sv[i].val;
      chk($sformatf("sv%0d.done_early", i), done, 0);
      chk_regs($sformatf("sv%0d", i));
      step();
      chk($sformatf("sv%0d.done", i), done, 1);
      chk($sformatf("sv%0d.busy", i), busy, 0);
    end

    // len=0: straight to DONE, nothing written
    start_run(3'd0);
    chk("len0.k0.busy", busy, 0);
    chk("len0.k0.done", done, 0);
    step();
    chk("len0.k1.busy", busy, 0);
    chk("len0.k1.done", done, 1);
    step();
    chk("len0.k2.done", done, 0);
    chk_regs("len0");

    // abort on the edge event 2 is due
    wr(0, 2'd0, 8'd6, 8'd4);
    wr(1, 2'd1, 8'd11, 8'd0);
    wr(2, 2'd2, 8'd16, 8'd4);
    wr(3, 2'd3, 8'd21, 8'd0);
    start_run(3'd4);
    for (int k = 0; k < 10; k++) step();
    exp_reg[0] = 8'd6; exp_reg[1] = 8'd11;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_regs("abort.k11");
    chk("abort.busy", busy, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("abort.no_done", seen_done, 0);
    chk("abort.busy_late", busy, 0);
    chk_regs("abort.late");

    // cfg_we and start during RUN ignored; held start reruns from IDLE
    wr(0, 2'd0, 8'h40, 8'd1);
    wr(1, 2'd0, 8'h41, 8'd0);
    cfg_len = 3'd2;
    start = 1'b1;
    step();
    step();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd1; cfg_val = 8'h99; cfg_dly = 8'd0;
    step();
    chk("hold.k2.a", a, 8'h40);
    step();
    cfg_we = 1'b0;
    chk("hold.k3.a", a, 8'h41);
    chk("hold.k3.busy", busy, 0);
    step();
    chk("hold.k4.done", done, 1);
    step();
    chk("hold.k5.busy", busy, 1);
    chk("hold.k5.a", a, 8'h41);
    step();
    chk("hold.k6.a", a, 8'h41);
    step();
    start = 1'b0;
    chk("hold.k7.a", a, 8'h40);
    chk("hold.k7.b", b, 8'd11);
    step();
    chk("hold.k8.a", a, 8'h41);
    step();
    chk("hold.k9.done", done, 1);
    step();

    // reset mid-run between events
    wr(0, 2'd0, 8'h77, 8'd2);
    wr(1, 2'd1, 8'h66, 8'd9);
    start_run(3'd2);
    for (int k = 0; k < 5; k++) step();
    chk("mid.k5.a", a, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst.abcd", {a, b, c, d}, 0);
    chk("mid.rst.busy", busy, 0);
    chk("mid.rst.done", done, 0);
    chk("mid.rst.mon", {mon_a, mon_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("mid.after.abcd", {a, b, c, d}, 0);
    chk("mid.after.busy", busy, 0);
    chk("mid.after.no_done", seen_done, 0);

    // table cleared by reset: entry 0 is {a, 0, dly0}
    start_run(3'd1);
    step();
    step();
    chk("clr.k2.done", done, 1);
    step();
    chk("clr.k3.a", a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stim_scheduler.md
STIM_SCHEDULER -- requirements
Module: stim_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 4, meaning the event-table depth (fixed at 4; the 2-bit index depends on it).
REQ-002 The block SHALL have parameter MON_DLY, default 5, meaning the number of cycles from a monitored edge to its pulse.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_we, input, 1 bit: writes one table entry.
REQ-006 The block SHALL have port cfg_idx, input, 2 bits: the table entry to write.
REQ-007 The block SHALL have port cfg_sel, input, 2 bits: the target register (0=a, 1=b, 2=c, 3=d).
REQ-008 The block SHALL have port cfg_val, input, 8 bits: the value to apply.
REQ-009 The block SHALL have port cfg_dly, input, 8 bits: the wait in cycles before this event is applied.
REQ-010 The block SHALL have port cfg_len, input, 3 bits: the number of events to run, sampled on start.
REQ-011 The block SHALL have port start, input, 1 bit: a level that begins a run when sampled high in IDLE.
REQ-012 The block SHALL have port abort, input, 1 bit: terminates a run.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse at run completion.
REQ-015 The block SHALL have ports a, b, c, d, output, 8 bits each: the scheduled target registers.
REQ-016 The block SHALL have ports mon_a and mon_b, output, 1 bit each: edge-monitor pulses.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-018 In IDLE, when start=1 and abort=0, the block SHALL latch len=min(cfg_len,4), set the event index to 0 and enter RUN.
REQ-019 If the latched len is 0, the block SHALL go from IDLE to DONE with no register writes.
REQ-020 Event i SHALL update its target register on the edge exactly cfg_dly[i]+1 clock edges after its reference edge.
REQ-021 The reference edge SHALL be the start-sampling edge for i=0 and the edge on which event i-1 was applied otherwise.
REQ-022 After the write of event len-1, the next state SHALL be DONE.
REQ-023 Events SHALL apply strictly in index order; when several events target the same register, the later index SHALL win.
REQ-024 Registers not targeted by a run SHALL hold their values.
REQ-025 cfg_we SHALL write entry {sel,val,dly} at cfg_idx when the FSM is in IDLE and SHALL be ignored in RUN and DONE.
REQ-026 start SHALL be ignored in RUN and DONE; start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-027 abort=1 in RUN SHALL return the FSM to IDLE on the next edge with no done pulse and no further writes, and a–d SHALL keep their current values.
REQ-028 If abort is asserted on the same edge as a scheduled write, abort SHALL win and the write SHALL be dropped.
REQ-029 Delay counters SHALL be 8-bit and never wrap; cfg_dly=255 SHALL give a 256-cycle spacing.

Reset
REQ-030 On rst_n=0 the block SHALL immediately clear a, b, c, d, busy, done, mon_a, mon_b and all monitor counters, and the FSM SHALL enter IDLE.
REQ-031 Table contents SHALL reset to all-zero entries (sel=0, val=0, dly=0).
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-033 With macro STIM_EDGE_MON_EN defined, each rising edge of a[0] SHALL produce a one-cycle mon_a pulse exactly MON_DLY cycles later, and each rising edge of b[1] SHALL likewise produce a mon_b pulse.
REQ-034 Each monitor SHALL have a single pending slot; an edge arriving while a pulse is pending SHALL be dropped.
REQ-035 Without STIM_EDGE_MON_EN, mon_a and mon_b SHALL be tied to 0 and no monitor logic SHALL exist; the port list SHALL be unchanged.

Verification
REQ-036 Scenario: table {a,5,dly4},{b,10,dly0},{c,15,dly4},{d,20,dly0}, len=4, start at edge T0 -> a=5@T0+5, b=10@T0+6, c=15@T0+11, d=20@T0+12, done@T0+13.
REQ-037 Scenario: with STIM_EDGE_MON_EN, the REQ-036 run -> a[0] rises @T0+5 giving mon_a @T0+10; b[1] rises @T0+6 giving mon_b @T0+11.
REQ-038 Scenario: len=0, start -> done one cycle later, busy never high, a–d unchanged.
REQ-039 Scenario: abort on the edge event 2 is due -> c unchanged, no done pulse, FSM in IDLE.
REQ-040 Scenario: cfg_we to idx0 during RUN, and start during RUN -> both ignored; a rerun after done uses the original entry 0.
REQ-041 Scenario: rst_n low mid-run between events -> all outputs read 0 asynchronously and a–d remain 0 after release.
